// File: rtl/nor_bist_pkg.sv
// nor_bist_pkg: state encodings, vector count and reference NOR shared by the BIST sequencer
package nor_bist_pkg;
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_DRIVE  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_SAMPLE = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
   localparam int NUM_VEC = 4;
   function automatic logic exp_nor(input logic a, input logic b);
      return ~(a | b);
   endfunction
endpackage

// File: rtl/nor_bist_settle_cnt.sv
// nor_bist_settle_cnt: loadable down-counter with zero flag timing the settle window
module nor_bist_settle_cnt #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt_q, cnt_d;
   // load wins over decrement; otherwise hold
   always_comb cnt_d = load ? load_val : dec ? cnt_q - W'(1) : cnt_q;
   // counter register
   always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
   assign zero = cnt_q == '0;
endmodule

// File: rtl/nor_bist_seq.sv
// nor_bist_seq: NOR gate self-test sequencer; NOR_BIST_FAIL_CAPTURE_EN adds first-fail capture outputs
module nor_bist_seq
   import nor_bist_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       Y,
   output logic       A,
   output logic       B,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_cnt
`ifdef NOR_BIST_FAIL_CAPTURE_EN
   ,
   output logic       first_fail_vld,
   output logic [1:0] first_fail_vec
`endif
);
   localparam int CW = ($clog2(SETTLE + 1) < 1) ? 1 : $clog2(SETTLE + 1);
   logic [2:0] state_q, state_d;
   logic [1:0] vec_q, vec_d;
   logic       a_q, a_d, b_q, b_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [2:0] err_q, err_d;
   logic       cnt_zero, mis, last_vec;
`ifdef NOR_BIST_FAIL_CAPTURE_EN
   logic       ff_vld_q, ff_vld_d;
   logic [1:0] ff_vec_q, ff_vec_d;
`endif
   nor_bist_settle_cnt #(.W(CW)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (state_q == S_DRIVE),
      .dec      (state_q == S_WAIT && !cnt_zero),
      .load_val (CW'(SETTLE - 1)),
      .zero     (cnt_zero)
   );
   // X/Z on Y must count as a mismatch, hence the case-equality test
   assign mis      = (Y === exp_nor(a_q, b_q)) ? 1'b0 : 1'b1;
   assign last_vec = vec_q == 2'(NUM_VEC - 1);
   // state register
   always_ff @(posedge clk) state_q <= rst ? S_IDLE : state_d;
   // next-state: one DRIVE/WAIT/SAMPLE pass per vector, then a single DONE cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = start ? S_DRIVE : S_IDLE;
         S_DRIVE:  state_d = S_WAIT;
         S_WAIT:   state_d = cnt_zero ? S_SAMPLE : S_WAIT;
         S_SAMPLE: state_d = last_vec ? S_DONE : S_DRIVE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end
   // datapath/outputs: vectors, mismatch accounting and run status
   always_comb begin
      vec_d  = vec_q;
      a_d    = a_q;
      b_d    = b_q;
      busy_d = busy_q;
      done_d = done_q;
      pass_d = pass_q;
      err_d  = err_q;
`ifdef NOR_BIST_FAIL_CAPTURE_EN
      ff_vld_d = ff_vld_q;
      ff_vec_d = ff_vec_q;
`endif
      case (state_q)
         S_IDLE: if (start) begin
            vec_d  = '0;
            busy_d = 1'b1;
            done_d = 1'b0;
            pass_d = 1'b0;
            err_d  = '0;
`ifdef NOR_BIST_FAIL_CAPTURE_EN
            ff_vld_d = 1'b0;
            ff_vec_d = '0;
`endif
         end
         S_DRIVE: begin
            a_d = vec_q[1];
            b_d = vec_q[0];
         end
         S_SAMPLE: begin
            err_d = err_q + {2'b00, mis};
            vec_d = last_vec ? vec_q : vec_q + 2'd1;
`ifdef NOR_BIST_FAIL_CAPTURE_EN
            if (mis && !ff_vld_q) begin
               ff_vld_d = 1'b1;
               ff_vec_d = {a_q, b_q};
            end
`endif
         end
         S_DONE: begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = err_q == '0;
         end
         default: ;
      endcase
   end
   // datapath registers, all cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         vec_q  <= '0;
         a_q    <= 1'b0;
         b_q    <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
         err_q  <= '0;
`ifdef NOR_BIST_FAIL_CAPTURE_EN
         ff_vld_q <= 1'b0;
         ff_vec_q <= '0;
`endif
      end else begin
         vec_q  <= vec_d;
         a_q    <= a_d;
         b_q    <= b_d;
         busy_q <= busy_d;
         done_q <= done_d;
         pass_q <= pass_d;
         err_q  <= err_d;
`ifdef NOR_BIST_FAIL_CAPTURE_EN
         ff_vld_q <= ff_vld_d;
         ff_vec_q <= ff_vec_d;
`endif
      end
   end
   assign A       = a_q;
   assign B       = b_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign pass    = pass_q;
   assign err_cnt = err_q;
`ifdef NOR_BIST_FAIL_CAPTURE_EN
   assign first_fail_vld = ff_vld_q;
   assign first_fail_vec = ff_vec_q;
`endif
endmodule

// File: tb/tb_nor_bist_seq.sv
// tb_nor_bist_seq: scoreboard bench for nor_bist_seq, SETTLE=2 and SETTLE=1 instances side by side
module tb_nor_bist_seq;
   typedef struct {
      int dedge;
      int err;
      int ffv;
   } exp_t;
   logic clk = 0, rst = 1, start = 0;
   logic [3:0] mask = 4'b0000;
   logic a2, b2, y2, bz2, dn2, pa2, a1, b1, y1, bz1, dn1, pa1;
   logic [2:0] ec2, ec1;
   logic fv2, fv1;
   logic [1:0] fe2, fe1;
   int total = 0, bad = 0, edge_n = 0, rst_e = -1;
   int cs2 = -1, cs1 = -1, free2 = 0, free1 = 0;
   logic dp2 = 0, dp1 = 0;
   exp_t q2[$], q1[$];

   always #5 clk = ~clk;

   // faulty gate: mask bit v flips the NOR result for input vector v={A,B}
   assign y2 = ~(a2 | b2) ^ mask[{a2, b2}];
   assign y1 = ~(a1 | b1) ^ mask[{a1, b1}];

   nor_bist_seq #(.SETTLE(2)) u_dut (
      .clk(clk), .rst(rst), .start(start), .Y(y2), .A(a2), .B(b2),
      .busy(bz2), .done(dn2), .pass(pa2), .err_cnt(ec2)
`ifdef NOR_BIST_FAIL_CAPTURE_EN
      , .first_fail_vld(fv2), .first_fail_vec(fe2)
`endif
   );
   nor_bist_seq #(.SETTLE(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .Y(y1), .A(a1), .B(b1),
      .busy(bz1), .done(dn1), .pass(pa1), .err_cnt(ec1)
`ifdef NOR_BIST_FAIL_CAPTURE_EN
      , .first_fail_vld(fv1), .first_fail_vec(fe1)
`endif
   );
`ifndef NOR_BIST_FAIL_CAPTURE_EN
   assign fv2 = 1'b0; assign fe2 = 2'b00; assign fv1 = 1'b0; assign fe1 = 2'b00;
`endif

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at edge %0d: got=%0d expected=%0d", nm, edge_n, got, exp);
      end
   endtask

   function automatic exp_t predict(input int dedge);
      exp_t e;
      e.dedge = dedge;
      e.err = $countones(mask);
      e.ffv = -1;
      for (int v = 3; v >= 0; v--) if (mask[v]) e.ffv = v;
      return e;
   endfunction

   // reference model: a start is accepted once the previous run's DONE has passed
   always @(posedge clk) begin
      edge_n++;
      if (rst) begin
         q2.delete(); q1.delete();
         rst_e = edge_n; cs2 = -1; cs1 = -1;
         free2 = edge_n + 1; free1 = edge_n + 1;
      end else if (start) begin
         if (edge_n >= free2) begin
            q2.push_back(predict(edge_n + 4 * 4 + 1));
            cs2 = edge_n; free2 = edge_n + 4 * 4 + 2;
         end
         if (edge_n >= free1) begin
            q1.push_back(predict(edge_n + 4 * 3 + 1));
            cs1 = edge_n; free1 = edge_n + 4 * 3 + 2;
         end
      end
   end

   task automatic mon(input string nm, input int s, input int cs, input logic a, input logic b,
                      input logic bz, input logic dn, input logic pa, input logic [2:0] ec,
                      input logic fv, input logic [1:0] fe, input bit rise, input bit have, input exp_t e);
      int k, v;
      if (edge_n == rst_e) begin
         chk({nm, " rst AB"}, {6'd0, a, b}, 8'd0);
         chk({nm, " rst busy/done/pass"}, {5'd0, bz, dn, pa}, 8'd0);
         chk({nm, " rst err_cnt"}, {5'd0, ec}, 8'd0);
      end
      k = edge_n - cs;
      if (cs >= 0 && k >= 0 && k <= 4 * (s + 2) + 1) begin
         chk({nm, " busy"}, {7'd0, bz}, {7'd0, k <= 4 * (s + 2)});
         if (k == 0) chk({nm, " done clr"}, {7'd0, dn}, 8'd0);
`ifdef NOR_BIST_FAIL_CAPTURE_EN
         if (k == 0) chk({nm, " ff clr"}, {7'd0, fv}, 8'd0);
`endif
         v = (k - 1) / (s + 2);
         if (k >= 1) chk({nm, " AB vec"}, {6'd0, a, b}, 8'(v > 3 ? 3 : v));
      end
      if (rise) begin
         if (!have) chk({nm, " unexpected done"}, 8'd1, 8'd0);
         else begin
            chk({nm, " done edge"}, 8'(edge_n - e.dedge), 8'd0);
            chk({nm, " err_cnt"}, {5'd0, ec}, 8'(e.err));
            chk({nm, " pass"}, {7'd0, pa}, {7'd0, e.err == 0});
`ifdef NOR_BIST_FAIL_CAPTURE_EN
            chk({nm, " ff vld"}, {7'd0, fv}, {7'd0, e.ffv >= 0});
            if (e.ffv >= 0) chk({nm, " ff vec"}, {6'd0, fe}, 8'(e.ffv));
`endif
         end
      end
   endtask

   // monitor: pops one expectation per done rise and checks run-window behaviour
   always @(negedge clk) begin
      exp_t e2, e1;
      bit r2, r1, h2, h1;
      r2 = (dn2 === 1'b1) && (dp2 !== 1'b1);
      r1 = (dn1 === 1'b1) && (dp1 !== 1'b1);
      h2 = 0; h1 = 0;
      if (r2 && q2.size() > 0) begin e2 = q2.pop_front(); h2 = 1; end
      if (r1 && q1.size() > 0) begin e1 = q1.pop_front(); h1 = 1; end
      mon("s2", 2, cs2, a2, b2, bz2, dn2, pa2, ec2, fv2, fe2, r2, h2, e2);
      mon("s1", 1, cs1, a1, b1, bz1, dn1, pa1, ec1, fv1, fe1, r1, h1, e1);
      dp2 = dn2; dp1 = dn1;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse();
      start = 1; cyc(1); start = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      cyc(2); rst = 0; cyc(2);
      pulse(); cyc(30);
      mask = 4'b1110; cyc(2); pulse(); cyc(30);
      mask = 4'b1111; cyc(2); pulse(); cyc(30);
      mask = 4'b0000; cyc(2);
      pulse(); cyc(9); rst = 1; cyc(1); rst = 0; cyc(3);
      pulse(); cyc(30);
      pulse(); cyc(5); pulse(); cyc(3);
      start = 1; cyc(20); start = 0; cyc(40);
      for (int i = 0; i < 8; i++) begin
         mask = 4'($urandom);
         cyc(2);
         for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
            pulse(); cyc($urandom_range(0, 25));
         end
         cyc(40);
      end
      chk("s2 leftover", 8'(q2.size()), 8'd0);
      chk("s1 leftover", 8'(q1.size()), 8'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/nor_bist_seq.md
Name: nor_bist_seq

Overview:
- Self-test stimulus sequencer that sits directly upstream of the 2-input NOR gate.
- Drives the gate inputs A/B through all four truth-table vectors, waits a programmable settle time, samples the gate output Y and compares it against ~(A|B).
- Reports busy/done/pass and a mismatch count; used for board-level and sim-level gate checkout.

Parameters:
- SETTLE, default 2, number of clk cycles A/B are held before Y is sampled; legal range 1..255, 0 is illegal.
- NUM_VEC, default 4, vector count (fixed 4 for a 2-input gate; not user-overridable).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a test run; sampled only in IDLE
- Y  input  1  output of the gate under test
- A  output  1  gate input A, registered
- B  output  1  gate input B, registered
- busy  output  1  high while a run is in progress
- done  output  1  high from run completion until next accepted start or rst
- pass  output  1  valid while done=1; 1 when err_cnt==0
- err_cnt  output  3  number of mismatching vectors in the last run, 0..4

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: A=0, B=0, busy=0, done=0, pass=0, err_cnt=0, vec=0, state=IDLE.
- States: IDLE, DRIVE, WAIT, SAMPLE, DONE.
- IDLE: start=1 -> clear err_cnt, done, pass; vec=0; busy=1; go to DRIVE. start=0 -> stay; A/B hold last values.
- DRIVE: A<=vec[1], B<=vec[0]; settle counter <= SETTLE-1; go to WAIT.
- WAIT: counter decrements each cycle; when it is 0, go to SAMPLE. WAIT lasts exactly SETTLE cycles.
- SAMPLE: expected = ~(A|B) using the registered A/B.
  - Y != expected, or Y is X/Z, counts as a mismatch: err_cnt+1.
  - vec==3 -> go to DONE; else vec+1 and go to DRIVE.
- DONE: busy<=0, done<=1, pass<=(err_cnt==0 after the final sample); go to IDLE.
- A/B are stable throughout WAIT and SAMPLE. Vector order is 00, 01, 10, 11.
- Latency: done rises 4*(SETTLE+2)+1 rising edges after the edge that samples start (17 edges for SETTLE=2).
- start while busy=1 or in DONE is ignored, with no queuing.
- start held high continuously -> a new run begins in the first IDLE cycle after DONE.
- err_cnt saturates at 4 by construction; its 3-bit width must not wrap.
- rst mid-run: all outputs return to reset values on that edge, and any partial result is discarded.

Optional Feature:
- Macro: NOR_BIST_FAIL_CAPTURE_EN.
- When defined, adds two outputs:
  - first_fail_vld (1 bit)
  - first_fail_vec (2 bits, {A,B} of the first mismatching vector)
- Capture happens in the SAMPLE of the first mismatch. Both outputs clear on rst and on an accepted start, and hold until then.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header nor_bist_pkg holds:
  - state encodings (3-bit localparams)
  - NUM_VEC=4
  - the expected-output function exp_nor(a,b)
- One natural sub-module: nor_bist_settle_cnt, a loadable down-counter with a zero flag, width $clog2(SETTLE+1), minimum 1.

Test Plan:
- Good gate, SETTLE=2: rst 2 cycles, pulse start -> A/B sequence 00, 01, 10, 11; done=1 at edge 17; pass=1, err_cnt=0.
- Stuck-at-1 Y model -> err_cnt=3, pass=0. With FAIL_CAPTURE: first_fail_vec=2'b01.
- Inverted-output model (Y=A|B) -> err_cnt=4, pass=0, no wrap. With FAIL_CAPTURE: first_fail_vec=2'b00.
- rst asserted during WAIT of vector 2 -> next edge A=B=0, busy=0, done=0, err_cnt=0. A fresh start then completes with pass=1.
- start pulsed while busy, and start held high across DONE -> mid-run pulse is ignored, so done is still at edge 17. Held start launches a second run on the first IDLE cycle after DONE, and done clears on that accepted start.
- SETTLE=1 -> done at edge 13; Y sampled exactly 1 cycle after each A/B update.
